// File: rtl/mux21_arbiter_if.sv
// ============================================================================
// mux21_arbiter_if : request/grant and mux-control bundle for mux21_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mux21_arbiter_if;
  logic REQA;
  logic REQB;
  logic SEL;
  logic Gbar;
  logic GNTA;
  logic GNTB;
  logic LAST;

  modport master (
    output REQA, REQB,
    input  SEL, Gbar, GNTA, GNTB, LAST
  );

  modport slave (
    input  REQA, REQB,
    output SEL, Gbar, GNTA, GNTB, LAST
  );
endinterface

`default_nettype wire

// File: rtl/mux21_arbiter.sv
// ============================================================================
// mux21_arbiter : round-robin, burst-bounded owner of a 2:1 gated mux's SEL/Gbar
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux21_arbiter #(
  parameter int MAXBURST = 4,
  parameter int CNTW     = 4
) (
  input  wire logic      CLK,
  input  wire logic      RSTbar,
  mux21_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] C_MAXBURST = CNTW'(MAXBURST);
  localparam logic [CNTW-1:0] C_ONE      = CNTW'(1);

  state_t          state_q, state_d;
  logic            t_q, t_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            gbar_q, gbar_d;
  logic            gnta_q, gnta_d;
  logic            gntb_q, gntb_d;

  logic            win;
  logic            req_t;
  logic            req_o;
  logic [CNTW-1:0] cnt_inc;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win     = 1'b0;
    req_t   = t_q ? bus.REQB : bus.REQA;
    req_o   = t_q ? bus.REQA : bus.REQB;
    cnt_inc = (cnt_q == C_MAXBURST) ? cnt_q : cnt_q + C_ONE;

    case (state_q)
      IDLE: begin
        if (bus.REQA || bus.REQB) begin
          // Contention goes to whoever did not own last; otherwise the lone requester.
          win = (bus.REQA && bus.REQB) ? ~last_q : bus.REQB;
          if (sel_q == win) begin
            state_d = win ? OWN_B : OWN_A;
            cnt_d   = C_ONE;
            last_d  = win;
          end else begin
            state_d = GAP;
            t_d     = win;
          end
        end
      end
      OWN_A: begin
        if (!bus.REQA) begin
          if (bus.REQB) begin
            state_d = GAP;
            t_d     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_q == C_MAXBURST) && bus.REQB) begin
          state_d = GAP;
          t_d     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OWN_B: begin
        if (!bus.REQB) begin
          if (bus.REQA) begin
            state_d = GAP;
            t_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_q == C_MAXBURST) && bus.REQA) begin
          state_d = GAP;
          t_d     = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (req_t) begin
          state_d = t_q ? OWN_B : OWN_A;
          cnt_d   = C_ONE;
          last_d  = t_q;
        end else if (req_o) begin
          t_d = ~t_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    sel_d = sel_q;
    case (state_d)
      OWN_A:   sel_d = 1'b0;
      OWN_B:   sel_d = 1'b1;
      GAP:     sel_d = t_d;
      default: sel_d = sel_q;
    endcase
    gnta_d = (state_d == OWN_A);
    gntb_d = (state_d == OWN_B);
    gbar_d = ~(gnta_d | gntb_d);
  end

  always_ff @(posedge CLK) begin
    if (!RSTbar) begin
      state_q <= IDLE;
      t_q     <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gbar_q  <= 1'b1;
      gnta_q  <= 1'b0;
      gntb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gbar_q  <= gbar_d;
      gnta_q  <= gnta_d;
      gntb_q  <= gntb_d;
    end
  end

  assign bus.SEL  = sel_q;
  assign bus.Gbar = gbar_q;
  assign bus.GNTA = gnta_q;
  assign bus.GNTB = gntb_q;
  assign bus.LAST = last_q;

endmodule

`default_nettype wire
